wb_txn_monitor: RTL and testbench

Synthesizable, parametrised Wishbone classic-cycle monitor. Passively observes every Wishbone bus signal on the SPI-core bus and captures each completed transfer into an internal FIFO of transaction records. Checks bus protocol, holding violations in sticky flags, and keeps saturating statistics. Serves as both an in-system debug tap and a scoreboard feed for the verification environment.

---
 rtl/wb_txn_monitor.sv | 233 +++++++++++++++++++++++
 tb/tb_wb_txn_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_txn_monitor.sv
// Passive Wishbone classic-cycle monitor: records completed transfers into a FIFO,
// flags protocol violations in sticky bits and keeps saturating statistics.
module wb_txn_monitor #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int SEL_W      = DATA_W / 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic [DATA_W-1:0] wb_dat_o,
    input  logic [SEL_W-1:0]  wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic              wb_ack_o,
    input  logic              wb_err_o,
    input  logic              wb_int_o,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic              rec_we,
    output logic [ADDR_W-1:0] rec_adr,
    output logic [SEL_W-1:0]  rec_sel,
    output logic [DATA_W-1:0] rec_data,
    output logic              rec_err,
    output logic              rec_timeout,
    output logic [CNT_W-1:0]  rec_wait,
    input  logic              clr_i,
    output logic [4:0]        viol_o,
    output logic              overflow_o,
    output logic [CNT_W-1:0]  txn_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  int_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STALL} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
        logic              err;
        logic              timeout;
        logic [CNT_W-1:0]  waits;
    } rec_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t            state, state_n;
    logic [ADDR_W-1:0] lat_adr;
    logic [DATA_W-1:0] lat_dat;
    logic [SEL_W-1:0]  lat_sel;
    logic              lat_we;
    logic [CNT_W-1:0]  wait_cnt, wait_n;
    logic              load, push;
    rec_t              push_rec;
    logic [4:0]        viol_set;

    logic req, term;
    assign req  = wb_cyc_i & wb_stb_i;
    assign term = wb_ack_o | wb_err_o;

    always_comb begin
        state_n  = state;
        wait_n   = wait_cnt;
        load     = 1'b0;
        push     = 1'b0;
        push_rec = '0;
        viol_set = '0;
        if (term && !req)
            viol_set[0] = 1'b1;
        if (wb_ack_o && wb_err_o)
            viol_set[1] = 1'b1;
        case (state)
            ST_IDLE: begin
                if (req && term) begin
                    push          = 1'b1;
                    push_rec.we   = wb_we_i;
                    push_rec.adr  = wb_adr_i;
                    push_rec.sel  = wb_sel_i;
                    push_rec.data = wb_we_i ? wb_dat_i : wb_dat_o;
                    push_rec.err  = wb_err_o;
                end else if (req) begin
                    load    = 1'b1;
                    wait_n  = CNT_W'(1);
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    viol_set[3] = 1'b1;
                    state_n     = ST_IDLE;
                end else begin
                    if (lat_adr != wb_adr_i || lat_we != wb_we_i || lat_sel != wb_sel_i ||
                        (lat_we && lat_dat != wb_dat_i))
                        viol_set[2] = 1'b1;
                    push_rec.we   = lat_we;
                    push_rec.adr  = lat_adr;
                    push_rec.sel  = lat_sel;
                    push_rec.data = lat_we ? lat_dat : wb_dat_o;
                    if (term) begin
                        push           = 1'b1;
                        push_rec.err   = wb_err_o;
                        push_rec.waits = wait_cnt;
                        state_n        = ST_IDLE;
                    end else if (wait_cnt >= TO_LAST) begin
                        // The cycle that brings the wait count up to TIMEOUT ends the transfer.
                        viol_set[4]      = 1'b1;
                        push             = 1'b1;
                        wait_n           = sat_inc(wait_cnt);
                        push_rec.timeout = 1'b1;
                        push_rec.waits   = wait_n;
                        state_n          = ST_STALL;
                    end else begin
                        wait_n = sat_inc(wait_cnt);
                    end
                end
            end
            ST_STALL: begin
                if (!req || term)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            lat_adr  <= '0;
            lat_dat  <= '0;
            lat_sel  <= '0;
            lat_we   <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            if (load) begin
                lat_adr <= wb_adr_i;
                lat_dat <= wb_dat_i;
                lat_sel <= wb_sel_i;
                lat_we  <= wb_we_i;
            end
        end
    end

    rec_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, pop, accept, drop;

    assign rec_valid = (count != '0);
    assign full      = (count == FULL_CNT);
    assign pop       = rec_valid & rec_ready;
    assign accept    = push & (!full | pop);
    assign drop      = push & full & !pop;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (accept)
            mem[wr_ptr] <= push_rec;
    end

    // Head fields are forced to zero while empty so nothing stale leaks out.
    rec_t head;
    assign head        = rec_valid ? mem[rd_ptr] : '0;
    assign rec_we      = head.we;
    assign rec_adr     = head.adr;
    assign rec_sel     = head.sel;
    assign rec_data    = head.data;
    assign rec_err     = head.err;
    assign rec_timeout = head.timeout;
    assign rec_wait    = head.waits;

    logic int_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            int_q      <= 1'b0;
            viol_o     <= '0;
            overflow_o <= 1'b0;
            txn_cnt    <= '0;
            drop_cnt   <= '0;
            int_cnt    <= '0;
        end else begin
            int_q <= wb_int_o;
            if (clr_i) begin
                viol_o     <= '0;
                overflow_o <= 1'b0;
                txn_cnt    <= '0;
                drop_cnt   <= '0;
                int_cnt    <= '0;
            end else begin
                viol_o <= viol_o | viol_set;
                if (drop)
                    overflow_o <= 1'b1;
                if (push)
                    txn_cnt <= sat_inc(txn_cnt);
                if (drop)
                    drop_cnt <= sat_inc(drop_cnt);
                if (wb_int_o && !int_q)
                    int_cnt <= sat_inc(int_cnt);
            end
        end
    end
endmodule

// File: tb/tb_wb_txn_monitor.sv
// Directed bench for wb_txn_monitor: stimulus pushes expected records into a
// queue that a negedge monitor pops and compares as the DUT hands records out.
module tb_wb_txn_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  adr = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
    logic        ack = 1'b0, err = 1'b0, int_line = 1'b0;
    logic        rec_ready = 1'b1;
    logic        clr = 1'b0;
    logic        rec_valid, rec_we, rec_err, rec_timeout, overflow;
    logic [4:0]  rec_adr;
    logic [3:0]  rec_sel;
    logic [31:0] rec_data;
    logic [15:0] rec_wait, txn_cnt, drop_cnt, int_cnt;
    logic [4:0]  viol;

    int tests = 0;
    int fails = 0;
    logic [59:0] exp_q[$];

    wb_txn_monitor dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_sel_i(sel),
        .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_ack_o(ack), .wb_err_o(err), .wb_int_o(int_line),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_we(rec_we), .rec_adr(rec_adr), .rec_sel(rec_sel), .rec_data(rec_data),
        .rec_err(rec_err), .rec_timeout(rec_timeout), .rec_wait(rec_wait),
        .clr_i(clr), .viol_o(viol), .overflow_o(overflow),
        .txn_cnt(txn_cnt), .drop_cnt(drop_cnt), .int_cnt(int_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [59:0] mkrec(input logic w, input logic [4:0] a, input logic [3:0] s,
                                          input logic [31:0] d, input logic e, input logic t,
                                          input logic [15:0] n);
        return {w, a, s, d, e, t, n};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic s, input logic w, input logic [4:0] a,
                                 input logic [31:0] di, input logic [31:0] dout,
                                 input logic [3:0] bs, input logic k, input logic e);
        cyc = c; stb = s; we = w; adr = a; dat_i = di; dat_o = dout; sel = bs; ack = k; err = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 5'h0, 32'h0, 32'h0, 4'h0, 0, 0);
    endtask

    task automatic clearStats();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
    endtask

    // Scoreboard monitor: every record handed to the consumer must match the queue head.
    always @(negedge clk) begin
        if (!rst && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_record: got %0h expected none",
                         {rec_we, rec_adr, rec_sel, rec_data, rec_err, rec_timeout, rec_wait});
            end else begin
                checkOutput("record",
                            {4'h0, rec_we, rec_adr, rec_sel, rec_data, rec_err, rec_timeout, rec_wait},
                            {4'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", rec_valid, 0);
        checkOutput("reset_viol", viol, 0);
        checkOutput("reset_txn", txn_cnt, 0);
        rst = 1'b0;
        idle(2);

        // Write with two wait states
        exp_q.push_back(mkrec(1, 5'h14, 4'h3, 32'h180, 0, 0, 16'd2));
        applyStimulus(1, 1, 1, 5'h14, 32'h180, 32'h0, 4'h3, 0, 0);
        applyStimulus(1, 1, 1, 5'h14, 32'h180, 32'h0, 4'h3, 0, 0);
        applyStimulus(1, 1, 1, 5'h14, 32'h180, 32'h0, 4'h3, 1, 0);
        idle(3);
        checkOutput("write_txn", txn_cnt, 1);
        checkOutput("write_viol", viol, 0);

        // Back-to-back zero-wait reads
        exp_q.push_back(mkrec(0, 5'h01, 4'hF, 32'hAAAA, 0, 0, 16'd0));
        exp_q.push_back(mkrec(0, 5'h01, 4'hF, 32'h5555, 0, 0, 16'd0));
        applyStimulus(1, 1, 0, 5'h01, 32'h0, 32'hAAAA, 4'hF, 1, 0);
        applyStimulus(1, 1, 0, 5'h01, 32'h0, 32'h5555, 4'hF, 1, 0);
        idle(4);
        checkOutput("b2b_txn", txn_cnt, 3);

        // Overflow: nine pushes into a stalled eight-deep FIFO
        rec_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(mkrec(1, 5'(i), 4'hF, 32'(i + 32'h100), 0, 0, 16'd0));
            applyStimulus(1, 1, 1, 5'(i), 32'(i + 32'h100), 32'h0, 4'hF, 1, 0);
        end
        idle(1);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_drop", drop_cnt, 1);
        checkOutput("ovf_txn", txn_cnt, 12);
        rec_ready = 1'b1;
        idle(10);
        clearStats();
        checkOutput("clr_ovf", overflow, 0);
        checkOutput("clr_txn", txn_cnt, 0);

        // Full FIFO with a pop in the ninth termination cycle: no drop
        rec_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(mkrec(1, 5'(i + 16), 4'h1, 32'(i + 32'h200), 0, 0, 16'd0));
            if (i == 8) rec_ready = 1'b1;
            applyStimulus(1, 1, 1, 5'(i + 16), 32'(i + 32'h200), 32'h0, 4'h1, 1, 0);
        end
        idle(12);
        checkOutput("nodrop_drop", drop_cnt, 0);
        checkOutput("nodrop_ovf", overflow, 0);
        checkOutput("nodrop_txn", txn_cnt, 9);
        clearStats();

        // Timeout after 16 unanswered cycles; the late ack must not create a record
        exp_q.push_back(mkrec(1, 5'h03, 4'hF, 32'h77, 0, 1, 16'd16));
        repeat (16) applyStimulus(1, 1, 1, 5'h03, 32'h77, 32'h0, 4'hF, 0, 0);
        applyStimulus(1, 1, 1, 5'h03, 32'h77, 32'h0, 4'hF, 1, 0);
        idle(4);
        checkOutput("timeout_viol", viol, 5'b10000);
        checkOutput("timeout_txn", txn_cnt, 1);
        clearStats();

        // Ack without a cycle
        applyStimulus(0, 0, 0, 5'h0, 32'h0, 32'h0, 4'h0, 1, 0);
        idle(1);
        checkOutput("spurious_viol", viol, 5'b00001);
        clearStats();

        // Address changes while waiting; latched address is recorded
        exp_q.push_back(mkrec(1, 5'h02, 4'hF, 32'h5, 0, 0, 16'd2));
        applyStimulus(1, 1, 1, 5'h02, 32'h5, 32'h0, 4'hF, 0, 0);
        applyStimulus(1, 1, 1, 5'h06, 32'h5, 32'h0, 4'hF, 0, 0);
        applyStimulus(1, 1, 1, 5'h06, 32'h5, 32'h0, 4'hF, 1, 0);
        idle(3);
        checkOutput("unstable_viol", viol, 5'b00100);
        clearStats();

        // Strobe dropped while waiting: abort, no record
        applyStimulus(1, 1, 0, 5'h04, 32'h0, 32'h0, 4'hF, 0, 0);
        applyStimulus(1, 0, 0, 5'h04, 32'h0, 32'h0, 4'hF, 0, 0);
        idle(3);
        checkOutput("abort_viol", viol, 5'b01000);
        checkOutput("abort_txn", txn_cnt, 0);
        clearStats();

        // Ack and err together
        exp_q.push_back(mkrec(0, 5'h07, 4'hF, 32'hBEEF, 1, 0, 16'd0));
        applyStimulus(1, 1, 0, 5'h07, 32'h0, 32'hBEEF, 4'hF, 1, 1);
        idle(3);
        checkOutput("ackerr_viol", viol, 5'b00010);
        clearStats();
        checkOutput("clr_viol", viol, 0);

        // Interrupt rising edges
        int_line = 1'b1; idle(1);
        int_line = 1'b0; idle(1);
        int_line = 1'b1; idle(2);
        int_line = 1'b0;
        checkOutput("int_cnt", int_cnt, 2);

        // Asynchronous reset mid-WAIT with three records queued
        rec_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 1, 1, 5'(i), 32'h300, 32'h0, 4'hF, 1, 0);
        applyStimulus(1, 1, 1, 5'h0A, 32'h300, 32'h0, 4'hF, 0, 0);
        #2;
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0;
        #1;
        checkOutput("arst_valid", rec_valid, 0);
        checkOutput("arst_txn", txn_cnt, 0);
        checkOutput("arst_int", int_cnt, 0);
        idle(2);
        rst = 1'b0;
        rec_ready = 1'b1;
        idle(1);
        exp_q.push_back(mkrec(1, 5'h09, 4'hF, 32'h99, 0, 0, 16'd1));
        applyStimulus(1, 1, 1, 5'h09, 32'h99, 32'h0, 4'hF, 0, 0);
        applyStimulus(1, 1, 1, 5'h09, 32'h99, 32'h0, 4'hF, 1, 0);
        idle(4);
        checkOutput("post_rst_txn", txn_cnt, 1);

        checkOutput("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
